// File: rtl/idct_pkg.sv
//------------------------------------------------------------------------------
// Module  : idct_pkg
// Brief   : Shared types, block geometry and zig-zag table for the IDCT front end
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package idct_pkg;

    localparam int W            = 16;
    localparam int BLK_WORDS    = 64;
    localparam int IDCT_LATENCY = 29;

    typedef logic signed [W-1:0] coef_t;

    // Entry i is the raster position of the i-th coefficient in JPEG zig-zag order
    localparam logic [5:0] ZZ_TO_RASTER [BLK_WORDS] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

`default_nettype wire

// File: rtl/idct_coef_loader_if.sv
//------------------------------------------------------------------------------
// Module  : idct_coef_loader_if
// Brief   : Coefficient stream in, parallel block and status out
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface idct_coef_loader_if #(
    parameter int W = idct_pkg::W
);
    import idct_pkg::*;

    logic [W-1:0]           in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [BLK_WORDS*W-1:0] blk_out;
    logic                   blk_valid;
    logic                   idct_out_valid;
    logic [15:0]            blk_cnt;
    logic                   err_len;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, blk_out, blk_valid, idct_out_valid, blk_cnt, err_len
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, blk_out, blk_valid, idct_out_valid, blk_cnt, err_len
    );

endinterface

`default_nettype wire

// File: rtl/idct_valid_delay.sv
//------------------------------------------------------------------------------
// Module  : idct_valid_delay
// Brief   : DEPTH-cycle strobe delay line with synchronous active-low clear
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module idct_valid_delay #(
    parameter int DEPTH = idct_pkg::IDCT_LATENCY
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    generate
        if (DEPTH <= 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk) begin
                if (!rst_n) r_q <= 1'b0;
                else        r_q <= i_d;
            end
            assign o_q = r_q;
        end else begin : g_chain
            logic [DEPTH-1:0] r_sr;
            always_ff @(posedge clk) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= {r_sr[DEPTH-2:0], i_d};
            end
            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/idct_coef_loader.sv
//------------------------------------------------------------------------------
// Module  : idct_coef_loader
// Brief   : De-zigzags a coefficient stream into a held 8x8 block for the IDCT
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module idct_coef_loader #(
    parameter int W            = idct_pkg::W,
    parameter int IDCT_LATENCY = idct_pkg::IDCT_LATENCY,
    parameter int ZIGZAG       = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    idct_coef_loader_if.slave   bus
);
    import idct_pkg::*;

    logic [5:0]             r_idx;
    logic [BLK_WORDS-1:0]   r_mask;
    logic [W-1:0]           r_stage [BLK_WORDS];
    logic [BLK_WORDS*W-1:0] r_blk_out;
    logic                   r_blk_valid;
    logic                   r_ready;
    logic                   r_err;
    logic [15:0]            r_cnt;

    logic [5:0]             w_pos;
    logic                   w_accept;
    logic                   w_commit;
    logic                   w_iov;

    generate
        if (ZIGZAG != 0) begin : g_zigzag
            assign w_pos = ZZ_TO_RASTER[r_idx];
        end else begin : g_raster
            assign w_pos = r_idx;
        end
    endgenerate

    assign w_accept = bus.in_valid & r_ready;
    assign w_commit = w_accept & (bus.in_last | (r_idx == 6'd63));

    // Stale staging words are harmless: the mask gates them out at commit
    always_ff @(posedge clk) begin
        if (w_accept) r_stage[w_pos] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_mask      <= '0;
            r_blk_out   <= '0;
            r_blk_valid <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_ready     <= 1'b1;
            r_blk_valid <= w_commit;
            if (w_commit) begin
                for (int k = 0; k < BLK_WORDS; k++) begin
                    if (w_pos == 6'(k))
                        r_blk_out[k*W +: W] <= bus.in_data;
                    else if (r_mask[k])
                        r_blk_out[k*W +: W] <= r_stage[k];
                    else
                        r_blk_out[k*W +: W] <= '0;
                end
                r_mask <= '0;
                r_idx  <= '0;
                r_cnt  <= r_cnt + 16'd1;
                if (!bus.in_last) r_err <= 1'b1;
            end else if (w_accept) begin
                r_mask[w_pos] <= 1'b1;
                r_idx         <= r_idx + 6'd1;
            end
        end
    end

    idct_valid_delay #(
        .DEPTH (IDCT_LATENCY)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (r_blk_valid),
        .o_q   (w_iov)
    );

    assign bus.in_ready       = r_ready;
    assign bus.blk_out        = r_blk_out;
    assign bus.blk_valid      = r_blk_valid;
    assign bus.idct_out_valid = w_iov;
    assign bus.blk_cnt        = r_cnt;
    assign bus.err_len        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_idct_coef_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_idct_coef_loader
// Brief   : Randomized self-checking bench for both ZIGZAG settings
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_idct_coef_loader;

    localparam int LAT   = 29;
    localparam int MAXC  = 16384;

    logic        clk;
    logic        rst_n;
    logic [15:0] d;
    logic        v;
    logic        l;

    idct_coef_loader_if #(.W(16)) ifz ();
    idct_coef_loader_if #(.W(16)) ifr ();

    assign ifz.in_data  = d;
    assign ifz.in_valid = v;
    assign ifz.in_last  = l;
    assign ifr.in_data  = d;
    assign ifr.in_valid = v;
    assign ifr.in_last  = l;

    idct_coef_loader #(.W(16), .IDCT_LATENCY(LAT), .ZIGZAG(1)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifz.slave)
    );

    idct_coef_loader #(.W(16), .IDCT_LATENCY(LAT), .ZIGZAG(0)) dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Zig-zag order derived by walking the anti-diagonals of the 8x8 grid
    int zz [64];
    initial begin
        int r, c;
        r = 0; c = 0;
        for (int i = 0; i < 64; i++) begin
            zz[i] = r * 8 + c;
            if (((r + c) % 2) == 0) begin
                if (c == 7)      r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7)      c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
    end

    // Behavioural model: state after each rising edge
    int          cyc = 0;
    int          rst_cyc = 0;
    bit          m_rdy = 0;
    bit          m_bv = 0;
    bit          m_err = 0;
    logic [15:0] m_cnt = 0;
    logic [15:0] beats [$];
    logic [15:0] m_blkz [64];
    logic [15:0] m_blkr [64];
    bit          bv_at [MAXC];

    initial for (int k = 0; k < 64; k++) begin m_blkz[k] = 0; m_blkr[k] = 0; end

    always @(posedge clk) begin
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, required below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        if (!rst_n) begin
            m_rdy = 0; m_bv = 0; m_err = 0; m_cnt = 0;
            beats.delete();
            for (int k = 0; k < 64; k++) begin m_blkz[k] = 0; m_blkr[k] = 0; end
            rst_cyc = cyc;
        end else begin
            m_bv = 0;
            if (v && m_rdy) begin
                beats.push_back(d);
                if (l || beats.size() == 64) begin
                    if (!l) m_err = 1;
                    for (int k = 0; k < 64; k++) begin m_blkz[k] = 0; m_blkr[k] = 0; end
                    for (int j = 0; j < beats.size(); j++) begin
                        m_blkz[zz[j]] = beats[j];
                        m_blkr[j]     = beats[j];
                    end
                    m_bv = 1;
                    m_cnt = m_cnt + 16'd1;
                    beats.delete();
                end
            end
            m_rdy = 1;
        end
        bv_at[cyc] = m_bv;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [1023:0] act, input bit zig);
        logic [1023:0] exp;
        for (int k = 0; k < 64; k++) exp[k*16 +: 16] = zig ? m_blkz[k] : m_blkr[k];
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < 64; k++) begin
                if (act[k*16 +: 16] !== exp[k*16 +: 16]) begin
                    $display("FAIL %s at cycle %0d: word %0d got %0h, required %0h",
                             name, cyc, k, act[k*16 +: 16], exp[k*16 +: 16]);
                    break;
                end
            end
        end
    endtask

    int last_bv  = -1000;
    int last_iov = -1000;

    always @(negedge clk) begin
        if (cyc > 0) begin
            bit e_iov;
            e_iov = (cyc - LAT >= rst_cyc) ? bv_at[cyc - LAT] : 1'b0;
            chk("z_in_ready",  {31'd0, ifz.in_ready},       {31'd0, m_rdy});
            chk("z_blk_valid", {31'd0, ifz.blk_valid},      {31'd0, m_bv});
            chk("z_blk_cnt",   {16'd0, ifz.blk_cnt},        {16'd0, m_cnt});
            chk("z_err_len",   {31'd0, ifz.err_len},        {31'd0, m_err});
            chk("z_idct_ov",   {31'd0, ifz.idct_out_valid}, {31'd0, e_iov});
            chk_blk("z_blk_out", ifz.blk_out, 1'b1);
            chk("r_blk_valid", {31'd0, ifr.blk_valid},      {31'd0, m_bv});
            chk("r_blk_cnt",   {16'd0, ifr.blk_cnt},        {16'd0, m_cnt});
            chk("r_err_len",   {31'd0, ifr.err_len},        {31'd0, m_err});
            chk("r_idct_ov",   {31'd0, ifr.idct_out_valid}, {31'd0, e_iov});
            chk_blk("r_blk_out", ifr.blk_out, 1'b0);
            if (ifz.blk_valid)      last_bv  = cyc;
            if (ifz.idct_out_valid) last_iov = cyc;
        end
    end

    task automatic send(input logic [15:0] dat, input bit last);
        v = 1'b1; d = dat; l = last;
        @(negedge clk);
        v = 1'b0; l = 1'b0;
    endtask

    task automatic idle(input int n);
        v = 1'b0; l = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; v = 1'b0; l = 1'b0; d = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Block 1: full 64 beats, in_last on the final one
        send(16'd23, 0); send(16'hFFFF, 0); send(16'hFFFE, 0);
        for (int i = 0; i < 61; i++) send(16'd0, i == 60);
        idle(LAT + 4);
        chk("lit_blk1_w0", {16'd0, ifz.blk_out[15:0]},    32'd23);
        chk("lit_blk1_w1", {16'd0, ifz.blk_out[31:16]},   32'h0000FFFF);
        chk("lit_blk1_w8", {16'd0, ifz.blk_out[143:128]}, 32'h0000FFFE);
        chk("lit_blk1_w2", {16'd0, ifz.blk_out[47:32]},   32'd0);
        chk("lit_blk1_cnt", {16'd0, ifz.blk_cnt}, 32'd1);
        chk("lit_model_w8", {16'd0, m_blkz[8]}, 32'h0000FFFE);
        chk("lit_latency", last_iov - last_bv, LAT);

        // Early EOB with zero fill
        send(16'd23, 0); send(16'hFFFF, 0); send(16'hFFFE, 1);
        idle(3);
        chk("lit_eob_w8", {16'd0, ifz.blk_out[143:128]}, 32'h0000FFFE);
        chk("lit_eob_cnt", {16'd0, ifz.blk_cnt}, 32'd2);

        // Ordering 0..63
        for (int i = 0; i < 64; i++) send(16'(i), i == 63);
        idle(2);
        chk("lit_ord_z_w8", {16'd0, ifz.blk_out[143:128]}, 32'd2);
        chk("lit_ord_r_w8", {16'd0, ifr.blk_out[143:128]}, 32'd8);

        // Missing in_last, then a single-beat block
        for (int i = 0; i < 64; i++) send(16'(100 + i), 0);
        send(16'd7, 1);
        idle(2);
        chk("lit_err_len", {31'd0, ifz.err_len}, 32'd1);
        chk("lit_err_w0", {16'd0, ifz.blk_out[15:0]}, 32'd7);

        // Back-to-back single-beat blocks
        send(16'd5, 1); send(16'd6, 1); send(16'd7, 1);
        idle(LAT + 4);

        // Random blocks with gaps, random lengths, occasional missing in_last
        for (int b = 0; b < 40; b++) begin
            int len;
            bit drop_last;
            len = $urandom_range(1, 64);
            drop_last = (len == 64) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < len; i++) begin
                send(16'($urandom), (i == len - 1) && !drop_last);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(LAT + 4);

        // Reset mid-block
        for (int i = 0; i < 10; i++) send(16'(200 + i), 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("lit_rst_cnt", {16'd0, ifz.blk_cnt}, 32'd0);
        chk("lit_rst_rdy", {31'd0, ifz.in_ready}, 32'd0);
        idle(1);
        for (int i = 0; i < 64; i++) send(16'(300 + i), i == 63);
        idle(LAT + 4);
        chk("lit_post_rst_cnt", {16'd0, ifz.blk_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
